// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register pending-producer scoreboard
// and a three-bit condition flag register {N,O,Z}.
//
// Register 0 is hardwired to zero and can never be marked pending. Reads are
// combinational and bypass a same-cycle writeback. The scoreboard bit of a
// register is set when a producer is issued to it and cleared by the matching
// writeback. If both happen on the same edge the set wins, because the issue
// belongs to a newer producer.
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous reset, active high
//   rd_addr   NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   NUM_RD packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy   bit i set while port i addresses a register still pending
//   wr_en     writeback enable
//   wr_addr   writeback destination
//   wr_data   writeback data
//   iss_en    reserve iss_addr as a pending destination
//   iss_addr  register to reserve
//   iss_err   the issue targets a register that is already pending
//   flag_in   new flag values {N,O,Z}
//   flag_en   per-flag update enables
//   flag_out  registered flags {N,O,Z}
module regfile_sb #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic                     iss_err,
   input  logic [2:0]               flag_in,
   input  logic [2:0]               flag_en,
   output logic [2:0]               flag_out
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] sb;
   logic [NUM_REGS-1:0] sb_nxt;
   logic                wr_valid;
   logic                iss_valid;

   assign wr_valid  = wr_en && (wr_addr != '0);
   assign iss_valid = iss_en && (iss_addr != '0);

   // Clear on writeback first, then set on issue, so a same-edge issue wins.
   always_comb begin
      sb_nxt = sb;
      if (wr_en) begin
         sb_nxt[wr_addr] = 1'b0;
      end
      if (iss_valid) begin
         sb_nxt[iss_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
         sb       <= '0;
         flag_out <= '0;
      end else begin
         if (wr_valid) begin
            regs[wr_addr] <= wr_data;
         end
         sb       <= sb_nxt;
         flag_out <= (flag_out & ~flag_en) | (flag_in & flag_en);
      end
   end

   // A writeback resolves the pending state in the same cycle it arrives.
   assign iss_err = iss_valid && sb[iss_addr] && !(wr_en && (wr_addr == iss_addr));

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              hit;

      assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
      assign hit = wr_en && (wr_addr == ra);

      // Register 0 is never written and the bypass excludes it, so it reads 0.
      // The bypass is held off during reset so reads stay at zero.
      assign rd_data[i*DATA_W +: DATA_W] = (!rst && hit && wr_valid) ? wr_data : regs[ra];
      assign rd_busy[i]                  = sb[ra] && !hit;
   end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int NUM_RD = 2;

   logic                     clk;
   logic                     rst;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     iss_err;
   logic [2:0]               flag_in;
   logic [2:0]               flag_en;
   logic [2:0]               flag_out;

   int checks = 0;
   int errors = 0;

   regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
      .clk      (clk),
      .rst      (rst),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .iss_err  (iss_err),
      .flag_in  (flag_in),
      .flag_en  (flag_en),
      .flag_out (flag_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge, then settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
      flag_in  = '0;
      flag_en  = '0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      idle();
      rd_addr = {4'd3, 4'd3};
      wr_en   = 1'b1;
      wr_addr = 4'd3;
      wr_data = 16'hABCD;
      iss_en  = 1'b1;
      iss_addr= 4'd3;
      flag_in = 3'b111;
      flag_en = 3'b111;
      #2;
      checks++;
      if (rd_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_rd_data got %h exp %h", rd_data, 32'h0);
      end
      tick();
      checks++;
      if (rd_busy !== 2'b00 || iss_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy_err got busy=%b err=%b exp busy=00 err=0", rd_busy, iss_err);
      end
      checks++;
      if (flag_out !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b exp %b", flag_out, 3'b000);
      end
      idle();
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (rd_data !== 32'h0 || rd_busy !== 2'b00) begin
         errors++;
         $display("FAIL reset_release got data=%h busy=%b exp data=0 busy=00", rd_data, rd_busy);
      end
   endtask

   task automatic test_write_read();
      idle();
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
      tick();
      idle();
      rd_addr = {4'd3, 4'd3};
      #1;
      checks++;
      if (rd_data !== {16'h1234, 16'h1234} || rd_busy !== 2'b00) begin
         errors++;
         $display("FAIL write_read_r3 got data=%h busy=%b exp data=12341234 busy=00", rd_data, rd_busy);
      end
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
      rd_addr = {4'd0, 4'd3};
      #1;
      checks++;
      if (rd_data[31:16] !== 16'h0000) begin
         errors++;
         $display("FAIL r0_no_bypass got %h exp %h", rd_data[31:16], 16'h0000);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_data !== {16'h0000, 16'h1234}) begin
         errors++;
         $display("FAIL r0_hardwired got %h exp %h", rd_data, {16'h0000, 16'h1234});
      end
   endtask

   task automatic test_bypass();
      idle();
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0001;
      tick();
      idle();
      rd_addr = {4'd5, 4'd3};
      #1;
      checks++;
      if (rd_data[31:16] !== 16'h0001) begin
         errors++;
         $display("FAIL bypass_old_r5 got %h exp %h", rd_data[31:16], 16'h0001);
      end
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
      #1;
      checks++;
      if (rd_data !== {16'hBEEF, 16'h1234}) begin
         errors++;
         $display("FAIL bypass_same_cycle got %h exp %h", rd_data, {16'hBEEF, 16'h1234});
      end
      tick();
      idle();
      rd_addr = {4'd3, 4'd5};
      #1;
      checks++;
      if (rd_data !== {16'h1234, 16'hBEEF}) begin
         errors++;
         $display("FAIL bypass_committed got %h exp %h", rd_data, {16'h1234, 16'hBEEF});
      end
   endtask

   task automatic test_scoreboard();
      idle();
      iss_en = 1'b1; iss_addr = 4'd7;
      rd_addr = {4'd0, 4'd7};
      #1;
      checks++;
      if (rd_busy !== 2'b00 || iss_err !== 1'b0) begin
         errors++;
         $display("FAIL sb_before_issue got busy=%b err=%b exp busy=00 err=0", rd_busy, iss_err);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_busy !== 2'b01 || rd_data[15:0] !== 16'h0000) begin
         errors++;
         $display("FAIL sb_pending got busy=%b data=%h exp busy=01 data=0000", rd_busy, rd_data[15:0]);
      end
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00AA;
      #1;
      checks++;
      if (rd_busy !== 2'b00 || rd_data[15:0] !== 16'h00AA) begin
         errors++;
         $display("FAIL sb_writeback got busy=%b data=%h exp busy=00 data=00aa", rd_busy, rd_data[15:0]);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_busy !== 2'b00 || rd_data[15:0] !== 16'h00AA) begin
         errors++;
         $display("FAIL sb_cleared got busy=%b data=%h exp busy=00 data=00aa", rd_busy, rd_data[15:0]);
      end
   endtask

   task automatic test_iss_err();
      idle();
      iss_en = 1'b1; iss_addr = 4'd4;
      tick();
      idle();
      iss_en = 1'b1; iss_addr = 4'd4;
      rd_addr = {4'd4, 4'd4};
      #1;
      checks++;
      if (iss_err !== 1'b1 || rd_busy !== 2'b11) begin
         errors++;
         $display("FAIL iss_err_pending got err=%b busy=%b exp err=1 busy=11", iss_err, rd_busy);
      end
      tick();
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0044;
      #1;
      checks++;
      if (iss_err !== 1'b0) begin
         errors++;
         $display("FAIL iss_err_with_wb got %b exp %b", iss_err, 1'b0);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_busy !== 2'b11 || rd_data !== {16'h0044, 16'h0044}) begin
         errors++;
         $display("FAIL iss_set_priority got busy=%b data=%h exp busy=11 data=00440044", rd_busy, rd_data);
      end
      iss_en = 1'b1; iss_addr = 4'd0;
      rd_addr = {4'd4, 4'd0};
      #1;
      checks++;
      if (iss_err !== 1'b0) begin
         errors++;
         $display("FAIL iss_r0_err got %b exp %b", iss_err, 1'b0);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_busy !== 2'b10) begin
         errors++;
         $display("FAIL iss_r0_busy got %b exp %b", rd_busy, 2'b10);
      end
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h0044;
      tick();
      idle();
      #1;
      checks++;
      if (rd_busy !== 2'b00) begin
         errors++;
         $display("FAIL iss_r4_release got %b exp %b", rd_busy, 2'b00);
      end
   endtask

   task automatic test_flags();
      idle();
      flag_in = 3'b111; flag_en = 3'b010;
      tick();
      checks++;
      if (flag_out !== 3'b010) begin
         errors++;
         $display("FAIL flags_en_o got %b exp %b", flag_out, 3'b010);
      end
      flag_in = 3'b000; flag_en = 3'b101;
      tick();
      checks++;
      if (flag_out !== 3'b010) begin
         errors++;
         $display("FAIL flags_en_nz got %b exp %b", flag_out, 3'b010);
      end
      flag_in = 3'b101; flag_en = 3'b111;
      tick();
      idle();
      tick();
      checks++;
      if (flag_out !== 3'b101) begin
         errors++;
         $display("FAIL flags_all_hold got %b exp %b", flag_out, 3'b101);
      end
   endtask

   task automatic test_concurrent();
      idle();
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h9999;
      iss_en = 1'b1; iss_addr = 4'd10;
      flag_in = 3'b010; flag_en = 3'b110;
      tick();
      idle();
      rd_addr = {4'd10, 4'd9};
      #1;
      checks++;
      if (rd_data[15:0] !== 16'h9999 || rd_busy !== 2'b10) begin
         errors++;
         $display("FAIL concurrent_rf got data=%h busy=%b exp data=9999 busy=10", rd_data[15:0], rd_busy);
      end
      checks++;
      if (flag_out !== 3'b011) begin
         errors++;
         $display("FAIL concurrent_flags got %b exp %b", flag_out, 3'b011);
      end
   endtask

   task automatic test_async_reset();
      idle();
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
      iss_en = 1'b1; iss_addr = 4'd6;
      flag_in = 3'b101; flag_en = 3'b111;
      tick();
      idle();
      rd_addr = {4'd6, 4'd2};
      #1;
      checks++;
      if (rd_data[15:0] !== 16'h5555 || rd_busy !== 2'b10 || flag_out !== 3'b101) begin
         errors++;
         $display("FAIL async_pre got data=%h busy=%b flags=%b exp data=5555 busy=10 flags=101",
                  rd_data[15:0], rd_busy, flag_out);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (rd_data !== 32'h0 || rd_busy !== 2'b00 || flag_out !== 3'b000) begin
         errors++;
         $display("FAIL async_reset got data=%h busy=%b flags=%b exp data=0 busy=00 flags=000",
                  rd_data, rd_busy, flag_out);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (rd_data !== 32'h0 || rd_busy !== 2'b00) begin
         errors++;
         $display("FAIL async_after got data=%h busy=%b exp data=0 busy=00", rd_data, rd_busy);
      end
   endtask

   initial begin
      rd_addr = '0;
      test_reset();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_iss_err();
      test_flags();
      test_concurrent();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
